// File: rtl/fwft_word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// fwft_word_serializer_pkg
//   Shared definitions for the message-link read path:
//   - serializer FSM state encoding
//   - beat-counter width helper
//   - link flit / message width constants used across the message path
// -----------------------------------------------------------------------------
package fwft_word_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Wide message word produced by the decoder, narrow flit carried on the link.
  localparam int LINK_MSG_WIDTH  = 64;
  localparam int LINK_FLIT_WIDTH = 8;

  // Beat counter width for a given beats-per-word ratio; never below one bit
  // so RATIO=1 still has a legal (constant-zero) counter.
  function automatic int calc_cw(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fwft_word_serializer.sv
// -----------------------------------------------------------------------------
// fwft_word_serializer
//   Drains wide words from a first-word-fall-through FIFO and emits each one as
//   RATIO narrow beats, LSB first, on a valid/ready stream. The next word is
//   popped on the same cycle the last beat is accepted, so consecutive words
//   stream with no bubble.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   fifo_empty  FWFT empty flag; fifo_dout is the head word when low
//   fifo_dout   FWFT head word [IN_WIDTH]
//   fifo_rd_en  pop strobe to the FIFO (combinational)
//   out_valid   beat valid
//   out_data    beat payload [OUT_WIDTH]
//   out_last    final beat of the current word
//   out_ready   downstream accept
//   busy        a word is held and not yet fully sent
// -----------------------------------------------------------------------------
module fwft_word_serializer
  import fwft_word_serializer_pkg::*;
#(
  parameter int IN_WIDTH  = LINK_MSG_WIDTH,
  parameter int OUT_WIDTH = LINK_FLIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CW    = calc_cw(RATIO);
  localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

  generate
    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
      $error("fwft_word_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
  endgenerate

  state_t              state, state_nxt;
  logic [IN_WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                is_last;

  assign is_last  = (cnt == LAST_BEAT);
  // The shift register is cleared whenever the FSM returns to IDLE, so the
  // low slice is already zero when no beat is offered.
  assign out_data = shreg[OUT_WIDTH-1:0];
  assign out_last = (state == ST_SEND) && is_last;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the case below can leave one unassigned and infer a latch.
    state_nxt  = state;
    shreg_nxt  = shreg;
    cnt_nxt    = cnt;
    fifo_rd_en = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          shreg_nxt  = fifo_dout;
          cnt_nxt    = '0;
          state_nxt  = ST_SEND;
        end
      end

      ST_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        // Under backpressure nothing moves: data, last and counter hold.
        if (out_ready) begin
          if (!is_last) begin
            shreg_nxt = shreg >> OUT_WIDTH;
            cnt_nxt   = cnt + CW'(1);
          end else if (!fifo_empty) begin
            // Last beat accepted with a word waiting: pop and reload in the
            // same cycle to keep the beat stream contiguous.
            fifo_rd_en = 1'b1;
            shreg_nxt  = fifo_dout;
            cnt_nxt    = '0;
          end else begin
            shreg_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: doc/fwft_word_serializer.md
Name: fwft_word_serializer

Overview:
- Reader-side companion to the team's first-word-fall-through (FWFT) FIFO.
- Drains wide words from a FWFT FIFO read port and sends each word as a sequence of narrow beats on a valid/ready stream.
- Used on inter-FPGA message links where the decoder pushes wide messages into a FIFO and the physical link carries narrow flits.
- Delivers full beat throughput with no bubble between consecutive words.

Parameters:
- IN_WIDTH, 64, width of a FIFO word in bits.
- OUT_WIDTH, 8, width of one output beat in bits. IN_WIDTH must be an integer multiple of OUT_WIDTH.
- RATIO, IN_WIDTH/OUT_WIDTH (localparam), beats per word.
- CW, max(1, $clog2(RATIO)) (localparam), beat counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fifo_empty  in  1  FWFT empty flag; when 0, fifo_dout holds the head word
- fifo_dout  in  IN_WIDTH  FWFT head word
- fifo_rd_en  out  1  pop strobe to the FIFO
- out_valid  out  1  beat valid
- out_data  out  OUT_WIDTH  beat payload
- out_last  out  1  final beat of the current word
- out_ready  in  1  downstream accept
- busy  out  1  a word is held and not yet fully sent

Behaviour:
- Reset (asynchronous assert, released synchronously to clk):
  - state=IDLE, shift register=0, beat counter=0.
  - out_valid=0, out_last=0, out_data=0, busy=0, fifo_rd_en=0.
  - A reset mid-word discards the partial word; nothing already popped is replayed.
- States: IDLE, SEND.
- IDLE:
  - fifo_rd_en = !fifo_empty (combinational).
  - On that cycle's edge: shift register <= fifo_dout, counter <= 0, state <= SEND.
  - Latency: FIFO non-empty to first out_valid is 1 cycle.
- SEND:
  - out_valid=1, busy=1.
  - out_data = shift register[OUT_WIDTH-1:0]; beats go out LSB-first.
  - out_last = (counter == RATIO-1).
- Beat transfer (out_valid & out_ready) when not the last beat:
  - Shift register >> OUT_WIDTH, zero fill.
  - counter <= counter + 1.
- Last-beat transfer when !fifo_empty:
  - fifo_rd_en=1 in the same cycle, reload shift register from fifo_dout, counter <= 0, stay in SEND.
  - No idle cycle between words.
- Last-beat transfer when fifo_empty: state <= IDLE, out_valid drops the next cycle.
- Backpressure (out_valid & !out_ready):
  - out_data, out_last and counter hold.
  - fifo_rd_en=0.
- fifo_rd_en is never asserted while fifo_empty=1 (assertion in the bench).
- fifo_rd_en is asserted at most once per word.
- out_valid, once high, never drops without a handshake (AXI-stream rule).
- RATIO=1:
  - Every beat is last, so out_last=1 whenever out_valid=1.
  - The block acts as a registered pass-through at one word per cycle when out_ready=1.
- Counter wraps only through the last-beat reload path; it never exceeds RATIO-1.
- Output throughput is 1 beat/cycle sustained while the FIFO stays non-empty and out_ready=1.
- Synthesis elaboration error if IN_WIDTH % OUT_WIDTH != 0.

Decomposition:
- A shared package holds:
  - the state encoding (ST_IDLE=1'b0, ST_SEND=1'b1);
  - the RATIO/CW derivation helper;
  - link flit width constants used by the rest of the message path.
- No sub-module is needed: a shift register plus counter plus a 2-state FSM.
- The bench instantiates the existing FWFT FIFO (DEPTH=4) as the source, so the pop interface is exercised against the real producer.

Test Plan:
- Single word: push 64'h0807060504030201, out_ready=1 → beats 01,02,…,08 on 8 consecutive cycles; out_last only on 08; fifo_rd_en exactly 1 cycle; out_valid low after.
- Back-to-back: push words A then B, out_ready=1 → 16 contiguous beats with no valid gap; fifo_rd_en pulses on the cycle of A's last beat.
- Backpressure: out_ready toggles 1,0,0,1,… during a word → out_data stable while stalled, no beat dropped or duplicated, order preserved.
- Empty guard: FIFO empty for 20 cycles, out_ready=1 → fifo_rd_en=0, out_valid=0 throughout; push one word at cycle 21 → first beat valid at cycle 22.
- Reset mid-word: assert reset after beat 3 of 8 → outputs 0 immediately (async); after release with the FIFO empty, no further beats appear; a new word then serializes from beat 0.
- RATIO=1 (IN_WIDTH=OUT_WIDTH=8): stream 4 words 11,22,33,44 → 4 beats on consecutive cycles, each with out_last=1.
